// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, condition codes, flag bit positions and
// the state/redirect types used by the execute-stage flag/branch unit.
package cpu_pkg;

    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_BR    = 11'b11010110000;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;    // opcode[10:3]
    localparam logic [7:0]  OP_BCOND = 8'b01010100;    // opcode[10:3]
    localparam logic [5:0]  OP_B     = 6'b000101;      // opcode[10:5]
    localparam logic [5:0]  OP_BL    = 6'b100101;      // opcode[10:5]

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_GE = 4'b1010;
    localparam logic [3:0] CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100;
    localparam logic [3:0] CC_LE = 4'b1101;
    localparam logic [3:0] CC_AL = 4'b1110;

    localparam int unsigned FLG_C = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_N = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } fbu_state_t;

    typedef enum logic [1:0] {
        RK_PCREL = 2'b00,
        RK_LINK  = 2'b01,
        RK_REG   = 2'b10
    } redirect_kind_t;

endpackage

// File: rtl/flag_branch_unit_if.sv
// EX-stage bundle between the pipeline (master) and the flag/branch unit (slave).
interface flag_branch_unit_if;

    logic        ex_valid;
    logic        ex_stall;
    logic [10:0] ex_opcode;
    logic [3:0]  ex_cond;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_overflow;
    logic        alu_negative;
    logic [3:0]  flags_q;
    logic        redirect;
    logic [1:0]  redirect_kind;
    logic        squash;
    logic        busy;

    modport master (
        output ex_valid, ex_stall, ex_opcode, ex_cond,
        output alu_carry, alu_zero, alu_overflow, alu_negative,
        input  flags_q, redirect, redirect_kind, squash, busy
    );

    modport slave (
        input  ex_valid, ex_stall, ex_opcode, ex_cond,
        input  alu_carry, alu_zero, alu_overflow, alu_negative,
        output flags_q, redirect, redirect_kind, squash, busy
    );

endinterface

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator over the committed {C,Z,V,N} flags.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       take
);

    logic z;
    logic n_eq_v;

    assign z      = flags[FLG_Z];
    assign n_eq_v = (flags[FLG_N] == flags[FLG_V]);

    always_comb begin
        take = 1'b0;
        case (cond)
            CC_EQ:   take = z;
            CC_NE:   take = ~z;
            CC_GE:   take = n_eq_v;
            CC_LT:   take = ~n_eq_v;
            CC_GT:   take = ~z & n_eq_v;
            CC_LE:   take = z | ~n_eq_v;
            CC_AL:   take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Execute-stage flag register and branch resolver: issues a one-cycle fetch
// redirect on a taken branch, then squashes FLUSH_DEPTH unstalled cycles.
module flag_branch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    flag_branch_unit_if.slave        bus
);

    fbu_state_t     state_q;
    logic [2:0]     cnt_q;
    logic [3:0]     flag_reg_q;
    logic           redirect_q;
    redirect_kind_t kind_q;

    logic           act;
    logic           is_adds, is_subs, is_cbz, is_bcond, is_b, is_bl, is_br;
    logic           cond_true;
    logic           taken;
    redirect_kind_t kind_d;

    assign act      = bus.ex_valid & ~bus.ex_stall & (state_q == IDLE);

    assign is_adds  = (bus.ex_opcode == OP_ADDS);
    assign is_subs  = (bus.ex_opcode == OP_SUBS);
    assign is_br    = (bus.ex_opcode == OP_BR);
    assign is_cbz   = (bus.ex_opcode[10:3] == OP_CBZ);
    assign is_bcond = (bus.ex_opcode[10:3] == OP_BCOND);
    assign is_b     = (bus.ex_opcode[10:5] == OP_B);
    assign is_bl    = (bus.ex_opcode[10:5] == OP_BL);

    // B.cond tests flags committed by an earlier op, not the current ALU result.
    cond_eval u_cond_eval (
        .flags (flag_reg_q),
        .cond  (bus.ex_cond),
        .take  (cond_true)
    );

    assign taken = (is_cbz & bus.alu_zero) | (is_bcond & cond_true) | is_b | is_bl | is_br;

    always_comb begin
        kind_d = RK_PCREL;
        if (is_bl) begin
            kind_d = RK_LINK;
        end else if (is_br) begin
            kind_d = RK_REG;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_reg_q <= 4'b0000;
        end else if (act & (is_adds | is_subs)) begin
            flag_reg_q <= {bus.alu_carry, bus.alu_zero, bus.alu_overflow, bus.alu_negative};
        end
    end

    // Redirect is re-evaluated every cycle so it can never outlive one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_q <= 1'b0;
            kind_q     <= RK_PCREL;
        end else begin
            redirect_q <= act & taken;
            kind_q     <= (act & taken) ? kind_d : RK_PCREL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (act & taken) begin
                        state_q <= FLUSH;
                        cnt_q   <= 3'(FLUSH_DEPTH);
                    end
                end
                FLUSH: begin
                    if (!bus.ex_stall) begin
                        if (cnt_q == 3'd1) begin
                            state_q <= IDLE;
                            cnt_q   <= 3'd0;
                        end else begin
                            cnt_q   <= cnt_q - 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    assign bus.flags_q       = flag_reg_q;
    assign bus.redirect      = redirect_q;
    assign bus.redirect_kind = kind_q;
    assign bus.squash        = (state_q == FLUSH);
    assign bus.busy          = (state_q == FLUSH);

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed self-checking bench for flag_branch_unit with FLUSH_DEPTH = 2.
module tb_flag_branch_unit;

    localparam logic [10:0] T_ADDS  = 11'b10101011000;
    localparam logic [10:0] T_SUBS  = 11'b11101011000;
    localparam logic [10:0] T_ADDI  = 11'b10010001000;
    localparam logic [10:0] T_CBZ   = 11'b10110100000;
    localparam logic [10:0] T_BCOND = 11'b01010100000;
    localparam logic [10:0] T_B     = 11'b00010100000;
    localparam logic [10:0] T_BL    = 11'b10010100000;
    localparam logic [10:0] T_BR    = 11'b11010110000;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   sq_cycles;

    flag_branch_unit_if bus ();

    flag_branch_unit #(
        .FLUSH_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // alu = {C,Z,V,N}
    task automatic drive(input logic v, input logic [10:0] op, input logic [3:0] cond,
                         input logic [3:0] alu);
        bus.ex_valid     = v;
        bus.ex_opcode    = op;
        bus.ex_cond      = cond;
        bus.alu_carry    = alu[3];
        bus.alu_zero     = alu[2];
        bus.alu_overflow = alu[1];
        bus.alu_negative = alu[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        drive(1'b0, 11'd0, 4'd0, 4'd0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        bus.ex_stall = 1'b0;
        drive(1'b0, 11'd0, 4'd0, 4'd0);
        tick();
        check("rst_flags", 32'(bus.flags_q), 32'h0);
        check("rst_redirect", 32'(bus.redirect), 32'h0);
        check("rst_kind", 32'(bus.redirect_kind), 32'h0);
        check("rst_squash", 32'(bus.squash), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        tick();

        // 1. flag write by ADDS, ADDI leaves flags alone
        drive(1'b1, T_ADDS, 4'd0, 4'b1001);
        tick();
        check("adds_flags", 32'(bus.flags_q), 32'h9);
        drive(1'b1, T_ADDI, 4'd0, 4'b0110);
        tick();
        check("addi_flags", 32'(bus.flags_q), 32'h9);
        check("addi_redirect", 32'(bus.redirect), 32'h0);

        // 2. SUBS sets N, then B.LT taken
        drive(1'b1, T_SUBS, 4'd0, 4'b0001);
        tick();
        check("subs_flags", 32'(bus.flags_q), 32'h1);
        drive(1'b1, T_BCOND, 4'b1011, 4'b1111);
        tick();
        check("blt_redirect", 32'(bus.redirect), 32'h1);
        check("blt_kind", 32'(bus.redirect_kind), 32'h0);
        check("blt_squash1", 32'(bus.squash), 32'h1);
        check("blt_flags_kept", 32'(bus.flags_q), 32'h1);
        idle_cycles(1);
        check("blt_redirect_off", 32'(bus.redirect), 32'h0);
        check("blt_squash2", 32'(bus.squash), 32'h1);
        check("blt_busy2", 32'(bus.busy), 32'h1);
        idle_cycles(1);
        check("blt_squash_end", 32'(bus.squash), 32'h0);
        check("blt_busy_end", 32'(bus.busy), 32'h0);

        // B.EQ with Z=0 and B.GE with N!=V are not taken
        drive(1'b1, T_BCOND, 4'b0000, 4'b0000);
        tick();
        check("beq_nt", 32'(bus.redirect), 32'h0);
        drive(1'b1, T_BCOND, 4'b1010, 4'b0000);
        tick();
        check("bge_nt", 32'(bus.redirect), 32'h0);

        // 3. CBZ not taken, then taken
        drive(1'b1, T_CBZ, 4'd0, 4'b0000);
        tick();
        check("cbz_nt_redirect", 32'(bus.redirect), 32'h0);
        check("cbz_nt_squash", 32'(bus.squash), 32'h0);
        drive(1'b1, T_CBZ, 4'd0, 4'b0100);
        tick();
        check("cbz_redirect", 32'(bus.redirect), 32'h1);
        check("cbz_kind", 32'(bus.redirect_kind), 32'h0);
        check("cbz_flags_kept", 32'(bus.flags_q), 32'h1);
        idle_cycles(2);
        check("cbz_busy_end", 32'(bus.busy), 32'h0);

        // 4. BL, ADDS squashed during flush, then BR
        drive(1'b1, T_BL, 4'd0, 4'b0000);
        tick();
        check("bl_redirect", 32'(bus.redirect), 32'h1);
        check("bl_kind", 32'(bus.redirect_kind), 32'h1);
        drive(1'b1, T_ADDS, 4'd0, 4'b1111);
        tick();
        check("flush_adds_flags", 32'(bus.flags_q), 32'h1);
        check("flush_redirect", 32'(bus.redirect), 32'h0);
        tick();
        check("flush_adds_flags2", 32'(bus.flags_q), 32'h1);
        check("bl_busy_end", 32'(bus.busy), 32'h0);
        drive(1'b1, T_BR, 4'd0, 4'b0000);
        tick();
        check("br_redirect", 32'(bus.redirect), 32'h1);
        check("br_kind", 32'(bus.redirect_kind), 32'h2);
        idle_cycles(2);
        check("br_busy_end", 32'(bus.busy), 32'h0);

        // Stall on the resolving cycle defers the branch
        drive(1'b1, T_B, 4'd0, 4'b0000);
        bus.ex_stall = 1'b1;
        tick();
        check("stall_res_redirect", 32'(bus.redirect), 32'h0);
        check("stall_res_busy", 32'(bus.busy), 32'h0);
        bus.ex_stall = 1'b0;
        tick();
        check("stall_res_late", 32'(bus.redirect), 32'h1);
        idle_cycles(2);

        // 5. stall mid-flush stretches squash, not redirect
        drive(1'b1, T_B, 4'd0, 4'b0000);
        tick();
        check("b_redirect", 32'(bus.redirect), 32'h1);
        check("b_kind", 32'(bus.redirect_kind), 32'h0);
        drive(1'b0, 11'd0, 4'd0, 4'd0);
        sq_cycles = 1;
        bus.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_redirect", 32'(bus.redirect), 32'h0);
            if (bus.squash) sq_cycles++;
        end
        bus.ex_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.squash) sq_cycles++;
        end
        check("stall_squash_total", 32'(sq_cycles), 32'd5);
        check("stall_busy_end", 32'(bus.busy), 32'h0);

        // 6. async reset mid-flush
        drive(1'b1, T_ADDS, 4'd0, 4'b0110);
        tick();
        check("pre_rst_flags", 32'(bus.flags_q), 32'h6);
        drive(1'b1, T_B, 4'd0, 4'b0000);
        tick();
        check("pre_rst_busy", 32'(bus.busy), 32'h1);
        drive(1'b0, 11'd0, 4'd0, 4'd0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_redirect", 32'(bus.redirect), 32'h0);
        check("arst_squash", 32'(bus.squash), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_flags", 32'(bus.flags_q), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        drive(1'b1, T_ADDS, 4'd0, 4'b1001);
        tick();
        check("post_rst_flags", 32'(bus.flags_q), 32'h9);
        drive(1'b1, T_CBZ, 4'd0, 4'b0100);
        tick();
        check("post_rst_redirect", 32'(bus.redirect), 32'h1);
        check("post_rst_squash", 32'(bus.squash), 32'h1);
        idle_cycles(3);
        check("post_rst_busy_end", 32'(bus.busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
